// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative radix-2 multiply/divide unit that sits beside the EX-stage ALU.
// One partial product or one quotient bit per clock. Signed operations work on magnitudes,
// and a final FIX cycle applies the signs and registers the HI/LO result pair.
module alu_muldiv #(
   parameter int OPR_L = 32,
   localparam int CNT_L = $clog2(OPR_L) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [OPR_L-1:0] A,
   input  logic [OPR_L-1:0] B,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [OPR_L-1:0] hi,
   output logic [OPR_L-1:0] lo,
   output logic             div_zero
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   state_t state_q, next_state;

   logic [CNT_L-1:0] cnt_q;
   logic [OPR_L-1:0] acc_hi, acc_lo, b_q;
   logic             is_div_q, prod_neg_q, rem_neg_q, dz_q;

   logic             accept;
   logic             a_neg, b_neg, b_zero;
   logic [OPR_L-1:0] a_mag, b_mag;
   logic [OPR_L:0]   mul_sum, div_shift, div_diff;
   logic [OPR_L-1:0] step_hi, step_lo;
   logic [2*OPR_L-1:0] prod_full;
   logic [OPR_L-1:0] fix_hi, fix_lo;

   assign busy = (state_q != IDLE);

   // Operand preparation: signed ops become magnitude plus sign flag; |MIN| stays as unsigned 2^(OPR_L-1)
   always_comb begin
      a_neg  = op[0] & A[OPR_L-1];
      b_neg  = op[0] & B[OPR_L-1];
      a_mag  = a_neg ? -A : A;
      b_mag  = b_neg ? -B : B;
      b_zero = (B == '0);
   end

   // One iteration step: shift-add for multiply, restoring shift-subtract for divide
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_q} : '0);
      div_shift = {acc_hi, acc_lo[OPR_L-1]};
      div_diff  = div_shift - {1'b0, b_q};
      step_hi   = '0;
      step_lo   = '0;
      if (is_div_q) begin
         if (!div_diff[OPR_L]) begin
            step_hi = div_diff[OPR_L-1:0];
            step_lo = {acc_lo[OPR_L-2:0], 1'b1};
         end else begin
            step_hi = div_shift[OPR_L-1:0];
            step_lo = {acc_lo[OPR_L-2:0], 1'b0};
         end
      end else begin
         step_hi = mul_sum[OPR_L:1];
         step_lo = {mul_sum[0], acc_lo[OPR_L-1:1]};
      end
   end

   // Sign fix-up of the final result; a zero divisor returns the raw dividend and all-ones quotient
   always_comb begin
      prod_full = {acc_hi, acc_lo};
      fix_hi    = '0;
      fix_lo    = '0;
      if (is_div_q) begin
         if (dz_q) begin
            fix_hi = acc_hi;
            fix_lo = '1;
         end else begin
            fix_hi = rem_neg_q  ? -acc_hi : acc_hi;
            fix_lo = prod_neg_q ? -acc_lo : acc_lo;
         end
      end else begin
         if (prod_neg_q) begin
            prod_full = -{acc_hi, acc_lo};
         end
         fix_hi = prod_full[2*OPR_L-1:OPR_L];
         fix_lo = prod_full[OPR_L-1:0];
      end
   end

   // Next-state logic; abort always returns to IDLE and also blocks a same-cycle start
   always_comb begin
      next_state = state_q;
      accept     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               accept     = 1'b1;
               next_state = CALC;
            end
         end
         CALC: begin
            if (abort) begin
               next_state = IDLE;
            end else if (dz_q || (cnt_q == CNT_L'(OPR_L - 1))) begin
               next_state = FIX;
            end
         end
         FIX: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= next_state;
      end
   end

   // Datapath: capture at accept, iterate in CALC, publish hi/lo and pulse done in FIX
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         acc_hi     <= '0;
         acc_lo     <= '0;
         b_q        <= '0;
         is_div_q   <= 1'b0;
         prod_neg_q <= 1'b0;
         rem_neg_q  <= 1'b0;
         dz_q       <= 1'b0;
         done       <= 1'b0;
         hi         <= '0;
         lo         <= '0;
         div_zero   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            cnt_q      <= '0;
            is_div_q   <= op[1];
            prod_neg_q <= a_neg ^ b_neg;
            rem_neg_q  <= a_neg;
            dz_q       <= op[1] & b_zero;
            acc_hi     <= (op[1] & b_zero) ? A : '0;
            acc_lo     <= a_mag;
            b_q        <= b_mag;
            div_zero   <= 1'b0;
         end else if (state_q == CALC && !abort) begin
            cnt_q <= cnt_q + CNT_L'(1);
            if (!dz_q) begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
            end
         end else if (state_q == FIX && !abort) begin
            hi       <= fix_hi;
            lo       <= fix_lo;
            div_zero <= dz_q;
            done     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Testbench for alu_muldiv (OPR_L=32): table of directed vectors plus hand-written
// sequences for start-while-busy, abort and asynchronous reset mid-operation.
module tb_alu_muldiv;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         abort = 1'b0;
   logic         busy, done, div_zero;
   logic [W-1:0] hi, lo;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string        name;
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_hi;
      logic [W-1:0] exp_lo;
      logic         exp_dz;
      int           exp_lat;
   } vec_t;

   vec_t vecs[14];

   alu_muldiv #(.OPR_L(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .A        (A),
      .B        (B),
      .abort    (abort),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo),
      .div_zero (div_zero)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Advance one rising edge and settle before sampling
   task automatic stepEdge();
      @(posedge clk);
      #1;
   endtask

   // Compare one value against its expectation and record the result
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue one operation and wait (bounded) for done; lat counts edges after the accept edge
   task automatic applyStimulus(input logic [1:0] op_v, input logic [W-1:0] a_v,
                                input logic [W-1:0] b_v, output int lat);
      bit got;
      op    = op_v;
      A     = a_v;
      B     = b_v;
      start = 1'b1;
      stepEdge();
      start = 1'b0;
      checkOutput("busy_after_accept", busy, 1);
      checkOutput("done_low_after_accept", done, 0);
      checkOutput("div_zero_cleared", div_zero, 0);
      lat = 0;
      got = 0;
      while (!got && lat < 100) begin
         stepEdge();
         lat++;
         if (done) got = 1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout: got no done expected done within 100 cycles");
      end else begin
         checkOutput("busy_low_on_done", busy, 0);
      end
   endtask

   initial begin
      int lat;
      int ndone;
      int done_at;
      logic [W-1:0] prev_hi, prev_lo;

      vecs[0]  = '{"multu_max",    2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
      vecs[1]  = '{"mult_neg3x5",  2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33};
      vecs[2]  = '{"mult_minxmin", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
      vecs[3]  = '{"div_neg7by2",  2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
      vecs[4]  = '{"divu_100by7",  2'b10, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 33};
      vecs[5]  = '{"div_minbym1",  2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
      vecs[6]  = '{"divu_by0",     2'b10, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, 2};
      vecs[7]  = '{"multu_x9",     2'b00, 32'h12345678, 32'h00000009, 32'h00000000, 32'hA3D70A38, 1'b0, 33};
      vecs[8]  = '{"div_7byneg2",  2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
      vecs[9]  = '{"mult_maxxm1",  2'b01, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0, 33};
      vecs[10] = '{"divu_by16",    2'b10, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 33};
      vecs[11] = '{"div_neg_by0",  2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 2};
      vecs[12] = '{"div_100byn7",  2'b11, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0, 33};
      vecs[13] = '{"multu_x0",     2'b00, 32'h00000005, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 33};

      // Reset state
      stepEdge();
      stepEdge();
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_hi", hi, 0);
      checkOutput("reset_lo", lo, 0);
      checkOutput("reset_div_zero", div_zero, 0);
      rst_n = 1'b1;
      stepEdge();

      // Table vectors, each started in the done cycle of the previous one
      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         checkOutput({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
         checkOutput({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
         checkOutput({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
         checkOutput({vecs[i].name, "_div_zero"}, div_zero, vecs[i].exp_dz);
      end

      // done lasts exactly one cycle
      stepEdge();
      checkOutput("done_single_pulse", done, 0);

      // start pulsed during a MULT is ignored, along with operand changes
      op = 2'b01; A = 32'hFFFFFFFD; B = 32'h00000005; start = 1'b1;
      stepEdge();
      start = 1'b0;
      ndone = 0;
      done_at = 0;
      for (int e = 1; e <= 45; e++) begin
         start = (e == 10);
         if (e == 10) begin
            op = 2'b00; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
         end
         stepEdge();
         if (done) begin
            ndone++;
            if (done_at == 0) done_at = e;
         end
      end
      start = 1'b0;
      checkOutput("busy_start_done_count", ndone, 1);
      checkOutput("busy_start_done_edge", done_at, 33);
      checkOutput("busy_start_hi", hi, 32'hFFFFFFFF);
      checkOutput("busy_start_lo", lo, 32'hFFFFFFF1);

      // Back-to-back: second start issued on the done cycle
      applyStimulus(2'b10, 32'h00000064, 32'h00000007, lat);
      applyStimulus(2'b00, 32'h12345678, 32'h00000009, lat);
      checkOutput("b2b_latency", lat, 33);
      checkOutput("b2b_lo", lo, 32'hA3D70A38);
      prev_hi = 32'h00000000;
      prev_lo = 32'hA3D70A38;
      stepEdge();

      // Abort at cycle 5: busy drops next cycle, no done, hi/lo unchanged
      op = 2'b00; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; start = 1'b1;
      stepEdge();
      start = 1'b0;
      for (int e = 1; e <= 5; e++) stepEdge();
      abort = 1'b1;
      stepEdge();
      abort = 1'b0;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_done", done, 0);
      ndone = 0;
      for (int e = 0; e < 40; e++) begin
         stepEdge();
         if (done) ndone++;
      end
      checkOutput("abort_no_done", ndone, 0);
      checkOutput("abort_hi_kept", hi, prev_hi);
      checkOutput("abort_lo_kept", lo, prev_lo);

      // Asynchronous reset at cycle 12 of an operation
      op = 2'b01; A = 32'hFFFFFFFD; B = 32'h00000005; start = 1'b1;
      stepEdge();
      start = 1'b0;
      for (int e = 1; e <= 12; e++) stepEdge();
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_busy", busy, 0);
      checkOutput("rst_mid_done", done, 0);
      checkOutput("rst_mid_hi", hi, 0);
      checkOutput("rst_mid_lo", lo, 0);
      checkOutput("rst_mid_div_zero", div_zero, 0);
      stepEdge();
      rst_n = 1'b1;
      stepEdge();

      // Unit works again after reset
      applyStimulus(2'b11, 32'hFFFFFFF9, 32'h00000002, lat);
      checkOutput("post_rst_latency", lat, 33);
      checkOutput("post_rst_hi", hi, 32'hFFFFFFFF);
      checkOutput("post_rst_lo", lo, 32'hFFFFFFFD);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
